ifetch_stage: RTL

Instruction fetch stage of the processor, directly upstream of decode/execute. It owns the program counter, issues requests to a synchronous-read instruction memory, and buffers returned instructions in a 2-entry queue. Decode consumes instructions through a valid/ready handshake and steers fetch back through redirect (branch/jump) and halt inputs.

---
 rtl/ifetch_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch: owns the PC, issues synchronous-read requests to imem and
// buffers responses in a 2-entry queue drained by decode via valid/ready.
module ifetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        err,
  output logic        dbg_state,
  output logic [1:0]  dbg_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc;
  logic [1:0]  count;
  logic        inflight;
  logic [15:0] tag;
  logic        squash;
  logic        err_q;
  logic [15:0] head_instr, head_pc, tail_instr, tail_pc;

  logic        run, pop, kill, issue, enq, misalign, good_redir;
  logic [2:0]  occ;

  // Handshake: the head transfers on a cycle where instr_valid and instr_ready
  // are both high; instr_valid never depends on instr_ready.
  always_comb begin
    run        = (state == ST_RUN);
    instr_valid = run && (count != 2'd0);
    pop        = instr_valid && instr_ready;
    occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    kill       = run && (halt || redirect_en);
    issue      = rst && run && !halt && !redirect_en && (occ <= 3'd1);
    // A response landing in a flush cycle belongs to the old path.
    enq        = inflight && !squash && !kill;
    misalign   = run && !halt && redirect_en && redirect_pc[0];
    good_redir = run && !halt && redirect_en && !redirect_pc[0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    if (halt || misalign) state_nx = ST_HALTED;
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      count      <= 2'd0;
      inflight   <= 1'b0;
      tag        <= 16'h0000;
      squash     <= 1'b0;
      err_q      <= 1'b0;
      head_instr <= 16'h0000;
      head_pc    <= 16'h0000;
      tail_instr <= 16'h0000;
      tail_pc    <= 16'h0000;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      squash   <= kill ? inflight : 1'b0;
      if (issue) begin
        pc  <= pc + 16'd2;
        tag <= pc;
      end else if (good_redir) begin
        pc <= redirect_pc;
      end
      if (misalign) err_q <= 1'b1;

      if (kill) begin
        count <= 2'd0;
      end else begin
        case ({enq, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_instr <= imem_rdata;
              head_pc    <= tag;
              count      <= 2'd1;
            end else begin
              tail_instr <= imem_rdata;
              tail_pc    <= tag;
              count      <= 2'd2;
            end
          end
          2'b01: begin
            if (count == 2'd2) begin
              head_instr <= tail_instr;
              head_pc    <= tail_pc;
            end
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head_instr <= imem_rdata;
              head_pc    <= tag;
            end else begin
              head_instr <= tail_instr;
              head_pc    <= tail_pc;
              tail_instr <= imem_rdata;
              tail_pc    <= tag;
            end
          end
          default: count <= count;
        endcase
      end
    end
  end

  // The issue rule keeps occupancy at or below two; an overflow means that broke.
  always_ff @(posedge clk) begin
    if (rst) assert (!(enq && (count == 2'd2) && !pop));
  end

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign instr     = head_instr;
  assign instr_pc  = head_pc;
  assign err       = err_q;
  assign dbg_state = state;
  assign dbg_count = count;

endmodule
